cnt_pattern_checker: RTL and testbench
======================================

// Module: cnt_pattern_checker
// PURPOSE
//  Receive end of the board counter-pattern loopback. The top-level drives an
//  incrementing WIDTH-bit count on output pins; this block samples that count
//  on input pins and checks each sample for +1 (mod 2^WIDTH) progression.
//  It reports lock, single-cycle error strobes and a saturating error count
//  for ILA/debug. It sits in the PLL clock domain, beside the pattern driver.
// PARAMETERS
//  WIDTH        4   pattern width, bits
//  SYNC_STAGES  2   input register stages (IO timing only, not CDC); >=1
//  LOCK_CNT     8   consecutive good samples needed to enter LOCKED; >=1
//  UNLOCK_ERR   4   consecutive bad samples in LOCKED that drop to SEEK; >=1
//  ALLOW_HOLD   1   1: sample equal to previous value counts as good
//  ERR_CNT_W    16  error counter width
// PORTS
//  clk      in   1          PLL output clock, same domain as pattern driver
//  rst_n    in   1          asynchronous active-low reset
//  en       in   1          check enable (typically pll_locked)
//  clr      in   1          synchronous clear of err_cnt
//  din      in   WIDTH      looped-back pattern from pins
//  locked   out  1          pattern acquired
//  err_stb  out  1          one-cycle pulse per bad sample while LOCKED
//  err_cnt  out  ERR_CNT_W  saturating count of bad samples while LOCKED
// BEHAVIOUR
//  - Reset: locked=0, err_stb=0, err_cnt=0, FSM=IDLE, pipe regs=0, exp=0.
//  - din passes through SYNC_STAGES flops -> ds. Checks use ds; exp holds the last value.
//  - Good sample: ds==exp+1 (mod 2^WIDTH, so 2^WIDTH-1 -> 0 is good), or
//    ALLOW_HOLD && ds==exp. Otherwise the sample is bad.
//  - FSM IDLE: en=0. Output locked=0. exp<=ds each cycle. en=1 -> SEEK.
//  - FSM SEEK: good -> run++. Bad -> run=0. exp<=ds always (resync).
//    run reaching LOCK_CNT -> LOCKED. locked asserts in the same cycle the
//    state register updates.
//  - FSM LOCKED: good -> exp<=ds, bad_run=0. Bad -> err_stb=1 next cycle,
//    err_cnt+1 saturating at all-ones, exp<=exp+1 (one glitch = one error),
//    bad_run++. bad_run reaching UNLOCK_ERR -> SEEK, run=0, exp<=ds.
//  - Latency: din -> err_stb is SYNC_STAGES+1 clk cycles.
//  - en=0 in any state -> IDLE next cycle. locked=0, err_stb=0, err_cnt held.
//  - clr wins over increment in the same cycle: err_cnt=0, err_stb still pulses.
//  - rst_n mid-operation: all state clears immediately, reacquire from IDLE.
//  - No errors are counted outside LOCKED.
// STRUCTURE
//  - Package cnt_chk_pkg: typedef enum logic [1:0] {IDLE, SEEK, LOCKED} state_t
//    and a function next_val(v) = v+1 mod 2^WIDTH.
//  - One sub-module reg_pipe #(W, STAGES): async-reset register chain used
//    for the din stages.
//  - Run counters are sized $clog2(max(LOCK_CNT,UNLOCK_ERR)+1).
// TESTING
//  - Reset, then en=1 with din incrementing 0,1,2.. -> locked=1 exactly
//    SYNC_STAGES+LOCK_CNT+1 cycles after the first sample; err_cnt=0.
//  - Locked; sequence 14,15,0,1 (WIDTH=4) -> no err_stb, locked stays 1.
//  - Locked; one sample replaced (5,6,9,8,9) -> one err_stb pulse, err_cnt=1,
//    locked stays 1.
//  - Locked; din stuck at 3 with ALLOW_HOLD=0 -> 4 err_stb pulses, err_cnt=4,
//    then locked=0. Resume counting -> relock after LOCK_CNT good samples.
//  - err_cnt preloaded near all-ones via errors (ERR_CNT_W=4): 20 errors -> 15.
//    clr coincident with an error -> err_cnt=0, err_stb=1.
//  - en drops while LOCKED -> locked=0 next cycle, err_cnt held.
//    rst_n pulse mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cnt_pattern_checker_pkg.sv
// -----------------------------------------------------------------------------
// cnt_chk_pkg
// Shared definitions for the counter-pattern loopback checker.
//   state_t  : checker FSM encoding (IDLE / SEEK / LOCKED)
//   next_val : successor of a pattern value, wrapping modulo 2^width
//   max_of   : larger of two integers, used for sizing the run counters
// -----------------------------------------------------------------------------
package cnt_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Widest pattern the helper below can handle.
    localparam int unsigned MAX_WIDTH = 32;

    // v+1 wrapped to 'width' bits, so the all-ones value rolls over to zero.
    function automatic logic [MAX_WIDTH-1:0] next_val(
        input logic [MAX_WIDTH-1:0] v,
        input int unsigned          width
    );
        logic [MAX_WIDTH-1:0] mask;
        if (width >= MAX_WIDTH) begin
            mask = {MAX_WIDTH{1'b1}};
        end else begin
            mask = (32'd1 << width) - 32'd1;
        end
        next_val = (v + 32'd1) & mask;
    endfunction

    function automatic int max_of(input int a, input int b);
        max_of = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cnt_pattern_checker_reg_pipe.sv
// -----------------------------------------------------------------------------
// reg_pipe
// Plain register chain with asynchronous active-low reset. Used on the
// looped-back pattern inputs purely to ease pin-to-register timing; both ends
// are in the same clock domain, so this is not a synchroniser.
// Ports:
//   clk    in   1        clock
//   rst_n  in   1        asynchronous active-low reset, clears every stage
//   d      in   W        data into the first stage
//   q      out  W        data out of the last stage (STAGES cycles later)
// -----------------------------------------------------------------------------
module reg_pipe #(
    parameter int W      = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_r [STAGES];

    // Shift the input one stage per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= {W{1'b0}};
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/cnt_pattern_checker.sv
// -----------------------------------------------------------------------------
// cnt_pattern_checker
// Receive side of the board counter-pattern loopback. The pins carry an
// incrementing WIDTH-bit count; each registered sample is checked for +1
// progression (mod 2^WIDTH). The block acquires lock after LOCK_CNT
// consecutive good samples, and while locked reports every bad sample as a
// one-cycle strobe plus a saturating error count. UNLOCK_ERR consecutive bad
// samples drop it back to searching.
// Ports:
//   clk      in   1          PLL clock, same domain as the pattern driver
//   rst_n    in   1          asynchronous active-low reset
//   en       in   1          check enable; low forces IDLE
//   clr      in   1          synchronous clear of err_cnt (wins over increment)
//   din      in   WIDTH      looped-back pattern
//   locked   out  1          pattern acquired
//   err_stb  out  1          one-cycle pulse per bad sample while locked
//   err_cnt  out  ERR_CNT_W  saturating count of bad samples while locked
// -----------------------------------------------------------------------------
module cnt_pattern_checker
    import cnt_chk_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = 8,
    parameter int UNLOCK_ERR  = 4,
    parameter int ALLOW_HOLD  = 1,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [WIDTH-1:0]     din,
    output logic                 locked,
    output logic                 err_stb,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // One counter width serves both the good-run and bad-run counters.
    localparam int RUN_W = $clog2(max_of(LOCK_CNT, UNLOCK_ERR) + 1);

    localparam logic [RUN_W-1:0]     RUN_ONE    = RUN_W'(1'b1);
    localparam logic [RUN_W-1:0]     RUN_ZERO   = {RUN_W{1'b0}};
    localparam logic [RUN_W-1:0]     LOCK_TGT   = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0]     UNLOCK_TGT = RUN_W'(UNLOCK_ERR);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE    = ERR_CNT_W'(1'b1);
    localparam logic [ERR_CNT_W-1:0] ERR_ZERO   = {ERR_CNT_W{1'b0}};
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = {ERR_CNT_W{1'b1}};

    // Registered pattern sample and its checks
    logic [WIDTH-1:0]     ds_s;
    logic [WIDTH-1:0]     inc_s;
    logic                 good_s;

    // FSM and tracking state
    state_t               state_r;
    state_t               state_nxt_s;
    logic [WIDTH-1:0]     exp_r;
    logic [WIDTH-1:0]     exp_nxt_s;
    logic [RUN_W-1:0]     run_r;
    logic [RUN_W-1:0]     run_nxt_s;
    logic [RUN_W-1:0]     bad_run_r;
    logic [RUN_W-1:0]     bad_run_nxt_s;
    logic                 err_hit_s;

    // Output registers
    logic                 locked_r;
    logic                 err_stb_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;
    logic [ERR_CNT_W-1:0] err_cnt_nxt_s;

    reg_pipe #(
        .W      (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_din_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din),
        .q     (ds_s)
    );

    // A hold is only tolerated when the driver may legitimately stall.
    assign inc_s  = WIDTH'(next_val(32'(exp_r), WIDTH));
    assign good_s = (ds_s == inc_s) || ((ALLOW_HOLD != 0) && (ds_s == exp_r));

    // Next-state, expectation tracking and error-hit decode.
    always_comb begin
        state_nxt_s   = state_r;
        exp_nxt_s     = exp_r;
        run_nxt_s     = run_r;
        bad_run_nxt_s = bad_run_r;
        err_hit_s     = 1'b0;

        if (!en) begin
            // Disabled: follow the pins so a later enable starts from fresh data.
            state_nxt_s   = IDLE;
            exp_nxt_s     = ds_s;
            run_nxt_s     = RUN_ZERO;
            bad_run_nxt_s = RUN_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s   = SEEK;
                    exp_nxt_s     = ds_s;
                    run_nxt_s     = RUN_ZERO;
                    bad_run_nxt_s = RUN_ZERO;
                end

                SEEK: begin
                    // Always resync to the pins while searching.
                    exp_nxt_s     = ds_s;
                    bad_run_nxt_s = RUN_ZERO;
                    if (good_s) begin
                        if ((run_r + RUN_ONE) >= LOCK_TGT) begin
                            state_nxt_s = LOCKED;
                            run_nxt_s   = RUN_ZERO;
                        end else begin
                            run_nxt_s = run_r + RUN_ONE;
                        end
                    end else begin
                        run_nxt_s = RUN_ZERO;
                    end
                end

                LOCKED: begin
                    run_nxt_s = RUN_ZERO;
                    if (good_s) begin
                        exp_nxt_s     = ds_s;
                        bad_run_nxt_s = RUN_ZERO;
                    end else begin
                        err_hit_s = 1'b1;
                        if ((bad_run_r + RUN_ONE) >= UNLOCK_TGT) begin
                            state_nxt_s   = SEEK;
                            exp_nxt_s     = ds_s;
                            bad_run_nxt_s = RUN_ZERO;
                        end else begin
                            // Advance as if the bad sample had been correct, so a
                            // single corrupted sample costs exactly one error.
                            exp_nxt_s     = inc_s;
                            bad_run_nxt_s = bad_run_r + RUN_ONE;
                        end
                    end
                end

                default: begin
                    state_nxt_s   = IDLE;
                    exp_nxt_s     = ds_s;
                    run_nxt_s     = RUN_ZERO;
                    bad_run_nxt_s = RUN_ZERO;
                end
            endcase
        end
    end

    // Saturating error count; a clear beats a coincident increment.
    always_comb begin
        err_cnt_nxt_s = err_cnt_r;
        if (clr) begin
            err_cnt_nxt_s = ERR_ZERO;
        end else if (err_hit_s && (err_cnt_r != ERR_MAX)) begin
            err_cnt_nxt_s = err_cnt_r + ERR_ONE;
        end else begin
            err_cnt_nxt_s = err_cnt_r;
        end
    end

    // FSM state, expected value and run counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            exp_r     <= {WIDTH{1'b0}};
            run_r     <= RUN_ZERO;
            bad_run_r <= RUN_ZERO;
        end else begin
            state_r   <= state_nxt_s;
            exp_r     <= exp_nxt_s;
            run_r     <= run_nxt_s;
            bad_run_r <= bad_run_nxt_s;
        end
    end

    // Output registers; locked tracks the state register on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_r  <= 1'b0;
            err_stb_r <= 1'b0;
            err_cnt_r <= ERR_ZERO;
        end else begin
            locked_r  <= (state_nxt_s == LOCKED);
            err_stb_r <= err_hit_s;
            err_cnt_r <= err_cnt_nxt_s;
        end
    end

    assign locked  = locked_r;
    assign err_stb = err_stb_r;
    assign err_cnt = err_cnt_r;

endmodule

// File: tb/tb_cnt_pattern_checker.sv
// -----------------------------------------------------------------------------
// Directed bench for cnt_pattern_checker. Two instances share the stimulus:
//   u_dut  : ALLOW_HOLD=0, ERR_CNT_W=4  (main checks, saturation at 15)
//   u_hold : ALLOW_HOLD=1, ERR_CNT_W=16 (repeated values must be accepted)
// Both use WIDTH=4, SYNC_STAGES=2, LOCK_CNT=8, UNLOCK_ERR=4.
// Every step drives din, waits for the rising edge and samples 1 ns later; a
// value driven at step j is judged at the edge of step j+2 and its result is
// visible right after that step.
// -----------------------------------------------------------------------------
module tb_cnt_pattern_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic [3:0]  din;

    logic        locked_a;
    logic        err_stb_a;
    logic [3:0]  err_cnt_a;
    logic        locked_b;
    logic        err_stb_b;
    logic [15:0] err_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cnt_pattern_checker #(
        .WIDTH(4), .SYNC_STAGES(2), .LOCK_CNT(8), .UNLOCK_ERR(4),
        .ALLOW_HOLD(0), .ERR_CNT_W(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .din(din),
        .locked(locked_a), .err_stb(err_stb_a), .err_cnt(err_cnt_a)
    );

    cnt_pattern_checker #(
        .WIDTH(4), .SYNC_STAGES(2), .LOCK_CNT(8), .UNLOCK_ERR(4),
        .ALLOW_HOLD(1), .ERR_CNT_W(16)
    ) u_hold (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .din(din),
        .locked(locked_b), .err_stb(err_stb_b), .err_cnt(err_cnt_b)
    );

    task automatic step(input logic [3:0] v);
        din = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; en = 1'b0; clr = 1'b0; din = 4'd0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (locked_a !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked_a); end
        n_checks++;
        if (err_stb_a !== 1'b0) begin n_fail++; $display("FAIL reset_err_stb: got %b want 0", err_stb_a); end
        n_checks++;
        if (err_cnt_a !== 4'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt_a); end
        n_checks++;
        if (locked_b !== 1'b0 || err_cnt_b !== 16'd0) begin
            n_fail++; $display("FAIL reset_hold_inst: got locked=%b cnt=%0d want 0/0", locked_b, err_cnt_b);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // From reset with din=0,1,2..: locked rises on the 11th edge (2 pipe + 1 IDLE->SEEK + 8 good).
    task automatic test_lock;
        en = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            step(4'(i));
            if (i == 9) begin
                n_checks++;
                if (locked_a !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %b want 0 at step %0d", locked_a, i); end
            end
            if (i == 10) begin
                n_checks++;
                if (locked_a !== 1'b1) begin n_fail++; $display("FAIL lock_time: got %b want 1 at step %0d", locked_a, i); end
            end
        end
        n_checks++;
        if (err_cnt_a !== 4'd0 || err_stb_a !== 1'b0) begin
            n_fail++; $display("FAIL lock_no_err: got cnt=%0d stb=%b want 0/0", err_cnt_a, err_stb_a);
        end
        n_checks++;
        if (locked_b !== 1'b1) begin n_fail++; $display("FAIL lock_hold_inst: got %b want 1", locked_b); end
    endtask

    // 11..15,0,1,2 : wrap 15->0 is a good step.
    task automatic test_wrap;
        for (int k = 0; k < 8; k++) begin
            step(4'(11 + k));
            n_checks++;
            if (err_stb_a !== 1'b0 || locked_a !== 1'b1) begin
                n_fail++; $display("FAIL wrap: got stb=%b locked=%b want 0/1 at step %0d", err_stb_a, locked_a, k);
            end
        end
        n_checks++;
        if (err_cnt_a !== 4'd0) begin n_fail++; $display("FAIL wrap_cnt: got %0d want 0", err_cnt_a); end
    endtask

    // 3,4,5,6,9,8,9,10,11 : the lone 9 (step 4) shows as err_stb after step 6.
    task automatic test_glitch;
        logic [3:0] seq [9];
        logic       want;
        seq = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd8, 4'd9, 4'd10, 4'd11};
        for (int i = 0; i < 9; i++) begin
            step(seq[i]);
            want = (i == 6);
            n_checks++;
            if (err_stb_a !== want || locked_a !== 1'b1) begin
                n_fail++; $display("FAIL glitch: got stb=%b locked=%b want %b/1 at step %0d", err_stb_a, locked_a, want, i);
            end
        end
        n_checks++;
        if (err_cnt_a !== 4'd1) begin n_fail++; $display("FAIL glitch_cnt: got %0d want 1", err_cnt_a); end
        n_checks++;
        if (err_cnt_b !== 16'd1) begin n_fail++; $display("FAIL glitch_cnt_hold: got %0d want 1", err_cnt_b); end
    endtask

    task automatic test_clr;
        clr = 1'b1;
        step(4'd12);
        clr = 1'b0;
        n_checks++;
        if (err_cnt_a !== 4'd0 || err_stb_a !== 1'b0) begin
            n_fail++; $display("FAIL clr: got cnt=%0d stb=%b want 0/0", err_cnt_a, err_stb_a);
        end
        n_checks++;
        if (err_cnt_b !== 16'd0) begin n_fail++; $display("FAIL clr_hold: got %0d want 0", err_cnt_b); end
    endtask

    // 13,14,15,0,1,2, 3 x8, 4..13 : four errors (steps 9..12), unlock at 12,
    // relock at step 23 after 8 good samples 4..11.
    task automatic test_stuck;
        logic [3:0] v;
        logic       want_stb;
        logic       want_lock;
        for (int j = 0; j < 24; j++) begin
            if (j < 6)       v = 4'(13 + j);
            else if (j < 14) v = 4'd3;
            else             v = 4'(j - 10);
            step(v);
            want_stb  = (j >= 9) && (j <= 12);
            want_lock = !((j >= 12) && (j <= 22));
            n_checks++;
            if (err_stb_a !== want_stb) begin
                n_fail++; $display("FAIL stuck_stb: got %b want %b at step %0d", err_stb_a, want_stb, j);
            end
            n_checks++;
            if (locked_a !== want_lock) begin
                n_fail++; $display("FAIL stuck_lock: got %b want %b at step %0d", locked_a, want_lock, j);
            end
            n_checks++;
            if (err_stb_b !== 1'b0 || locked_b !== 1'b1) begin
                n_fail++; $display("FAIL stuck_hold_inst: got stb=%b locked=%b want 0/1 at step %0d", err_stb_b, locked_b, j);
            end
        end
        n_checks++;
        if (err_cnt_a !== 4'd4) begin n_fail++; $display("FAIL stuck_cnt: got %0d want 4", err_cnt_a); end
        n_checks++;
        if (err_cnt_b !== 16'd0) begin n_fail++; $display("FAIL stuck_cnt_hold: got %0d want 0", err_cnt_b); end
    endtask

    // 20 isolated glitches (bit 3 flipped on odd samples) push 4 -> 15 saturated,
    // then a glitch judged in the same cycle as clr.
    task automatic test_saturate;
        logic [3:0] v;
        logic       want;
        int         pulses;
        pulses = 0;
        for (int s = 0; s < 42; s++) begin
            v = 4'(14 + s);
            if (s < 40 && (s % 2) == 1) v = v ^ 4'd8;
            step(v);
            if (err_stb_a === 1'b1) pulses++;
            want = (s >= 3) && ((s % 2) == 1);
            n_checks++;
            if (err_stb_a !== want || locked_a !== 1'b1) begin
                n_fail++; $display("FAIL sat_stb: got stb=%b locked=%b want %b/1 at step %0d", err_stb_a, locked_a, want, s);
            end
        end
        n_checks++;
        if (pulses != 20) begin n_fail++; $display("FAIL sat_pulses: got %0d want 20", pulses); end
        n_checks++;
        if (err_cnt_a !== 4'd15) begin n_fail++; $display("FAIL sat_cnt: got %0d want 15", err_cnt_a); end
        n_checks++;
        if (err_cnt_b !== 16'd20) begin n_fail++; $display("FAIL sat_cnt_hold: got %0d want 20", err_cnt_b); end

        step(4'd0);          // glitch: 8 expected
        step(4'd9);
        n_checks++;
        if (err_cnt_a !== 4'd15 || err_stb_a !== 1'b0) begin
            n_fail++; $display("FAIL sat_hold: got cnt=%0d stb=%b want 15/0", err_cnt_a, err_stb_a);
        end
        clr = 1'b1;
        step(4'd10);         // glitch judged on this edge
        clr = 1'b0;
        n_checks++;
        if (err_cnt_a !== 4'd0 || err_stb_a !== 1'b1) begin
            n_fail++; $display("FAIL clr_vs_err: got cnt=%0d stb=%b want 0/1", err_cnt_a, err_stb_a);
        end
        n_checks++;
        if (err_cnt_b !== 16'd0 || err_stb_b !== 1'b1) begin
            n_fail++; $display("FAIL clr_vs_err_hold: got cnt=%0d stb=%b want 0/1", err_cnt_b, err_stb_b);
        end
        step(4'd11);
        n_checks++;
        if (err_cnt_a !== 4'd0 || err_stb_a !== 1'b0) begin
            n_fail++; $display("FAIL clr_after: got cnt=%0d stb=%b want 0/0", err_cnt_a, err_stb_a);
        end
    endtask

    // One counted error, then en drops while a bad sample is being judged.
    task automatic test_en_drop;
        step(4'd12);
        step(4'd5);          // glitch: 13 expected
        step(4'd3);          // glitch: 14 expected (judged with en=0)
        step(4'd15);
        n_checks++;
        if (err_stb_a !== 1'b1 || err_cnt_a !== 4'd1 || locked_a !== 1'b1) begin
            n_fail++; $display("FAIL en_pre: got stb=%b cnt=%0d locked=%b want 1/1/1", err_stb_a, err_cnt_a, locked_a);
        end
        en = 1'b0;
        step(4'd0);
        n_checks++;
        if (locked_a !== 1'b0 || err_stb_a !== 1'b0 || err_cnt_a !== 4'd1) begin
            n_fail++; $display("FAIL en_drop: got locked=%b stb=%b cnt=%0d want 0/0/1", locked_a, err_stb_a, err_cnt_a);
        end
        step(4'd1);
        n_checks++;
        if (locked_a !== 1'b0 || err_cnt_a !== 4'd1 || locked_b !== 1'b0) begin
            n_fail++; $display("FAIL en_idle: got locked=%b cnt=%0d locked_b=%b want 0/1/0", locked_a, err_cnt_a, locked_b);
        end
        en = 1'b1;
        for (int k = 0; k < 20; k++) step(4'(2 + k));
        n_checks++;
        if (locked_a !== 1'b1 || err_cnt_a !== 4'd1) begin
            n_fail++; $display("FAIL en_relock: got locked=%b cnt=%0d want 1/1", locked_a, err_cnt_a);
        end
    endtask

    task automatic test_reset_mid;
        #2 rst_n = 1'b0;     // between clock edges
        #1;
        n_checks++;
        if (locked_a !== 1'b0 || err_stb_a !== 1'b0 || err_cnt_a !== 4'd0) begin
            n_fail++; $display("FAIL reset_mid: got locked=%b stb=%b cnt=%0d want 0/0/0", locked_a, err_stb_a, err_cnt_a);
        end
        n_checks++;
        if (locked_b !== 1'b0) begin n_fail++; $display("FAIL reset_mid_hold: got %b want 0", locked_b); end
        din = 4'd0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        test_lock();
    endtask

    initial begin
        test_reset();
        test_lock();
        test_wrap();
        test_glitch();
        test_clr();
        test_stuck();
        test_saturate();
        test_en_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
